pixel_write_arbiter: RTL and testbench
======================================

// Module: pixel_write_arbiter
// PURPOSE
//  Shares the single write port of the frame-buffer pixel memory between two point
//  generators (e.g. inside-circle and outside-circle dart plotters) using round-robin.
//  Range-checks each accepted point, registers it onto writeX/writeY/wrEnable, and keeps
//  saturating counts of written and dropped points for the status display.
// PARAMETERS
//  MAX_X    9'd479   largest legal write X; larger X is dropped
//  MAX_Y    9'd479   largest legal write Y; larger Y is dropped
//  CNT_W    20       width of count_written
//  DROP_W   16       width of count_dropped
// PORTS
//  clk            in   1       system clock, all state on rising edge
//  reset          in   1       asynchronous, active-high reset
//  enable         in   1       1 = arbitration allowed; 0 = accept nothing
//  req0_valid     in   1       requester 0 has a point
//  req0_x         in   9       requester 0 X coordinate
//  req0_y         in   9       requester 0 Y coordinate
//  req0_ready     out  1       requester 0 point accepted this cycle (combinational)
//  req1_valid     in   1       requester 1 has a point
//  req1_x         in   9       requester 1 X coordinate
//  req1_y         in   9       requester 1 Y coordinate
//  req1_ready     out  1       requester 1 point accepted this cycle (combinational)
//  writeX         out  9       to pixel memory write X (registered)
//  writeY         out  9       to pixel memory write Y (registered)
//  wrEnable       out  1       to pixel memory write strobe (registered, 1-cycle pulse per point)
//  last_grant     out  1       requester most recently granted (registered)
//  count_written  out  CNT_W   points written, saturates at all-ones
//  count_dropped  out  DROP_W  points dropped by range check, saturates at all-ones
// BEHAVIOUR
//  - Reset (async, immediate): writeX=0, writeY=0, wrEnable=0, last_grant=1,
//    count_written=0, count_dropped=0. The first contended grant after reset goes to req0.
//  - Handshake: a point transfers on a cycle where reqN_valid && reqN_ready. Ready depends on
//    valid, enable and last_grant only, never on the other ready. At most one ready is high.
//  - Grant (combinational):
//    - enable=0 -> both ready=0.
//    - Only one valid -> that requester is granted.
//    - Both valid -> the requester != last_grant is granted.
//    - Neither valid -> no grant.
//  - On a grant edge:
//    - last_grant <= granted index.
//    - writeX/writeY <= granted coordinates.
//    - In range (x<=MAX_X && y<=MAX_Y): wrEnable<=1, count_written+1.
//    - Out of range: wrEnable<=0, count_dropped+1.
//  - No grant: wrEnable<=0. writeX/writeY and last_grant hold.
//  - Latency: accepted point appears on writeX/writeY with wrEnable=1 exactly 1 cycle after the
//    handshake edge, so it is written to the pixel memory on the following edge.
//  - Throughput: 1 point/cycle. Under continuous contention the grants alternate 0,1,0,1...
//  - Counters saturate: at all-ones they stay at all-ones and do not wrap.
//  - Boundaries: x==MAX_X / y==MAX_Y are legal. Dropped points still assert ready, so a
//    requester is never stalled by bad data.
//  - enable falling while both valid: no grant that cycle, wrEnable=0 next cycle.
//    last_grant is kept, so fairness resumes where it left off.
//  - Reset asserted mid-stream: a pending wrEnable pulse is killed at once. Points accepted
//    in the reset cycle are discarded and not counted.
// TESTING
//  1 reset, then req0 valid with (10,20), enable=1 -> req0_ready=1; next cycle writeX=10,
//    writeY=20, wrEnable=1, count_written=1.
//  2 both valid for 6 cycles -> grants 0,1,0,1,0,1; wrEnable high 6 consecutive cycles;
//    last_grant toggles each cycle.
//  3 req1 (480,5) then (479,479) -> first: wrEnable=0, count_dropped=1; second: written,
//    count_written=1.
//  4 enable=0 with both valid for 3 cycles -> both ready=0, wrEnable=0, counters unchanged;
//    re-enable -> grant goes to the requester != last_grant.
//  5 force count_written to all-ones-1, write 3 legal points -> count stays all-ones.
//  6 assert reset between handshake and output cycle -> wrEnable=0 immediately, all
//    outputs at reset values, first contended grant after release is req0.

Source files
------------

// File: rtl/pixel_write_arbiter_if.sv
// Requester handshakes and pixel-memory write bus shared by the two point
// generators (master side) and the write arbiter (slave side).
interface pixel_write_arbiter_if;
    logic       req0_valid;
    logic [8:0] req0_x;
    logic [8:0] req0_y;
    logic       req0_ready;
    logic       req1_valid;
    logic [8:0] req1_x;
    logic [8:0] req1_y;
    logic       req1_ready;
    logic [8:0] writeX;
    logic [8:0] writeY;
    logic       wrEnable;

    // A point moves on any rising edge where reqN_valid && reqN_ready; ready is
    // combinational from valid/enable/last_grant only and at most one is high.
    modport master (
        output req0_valid, req0_x, req0_y,
        output req1_valid, req1_x, req1_y,
        input  req0_ready, req1_ready,
        input  writeX, writeY, wrEnable
    );

    modport slave (
        input  req0_valid, req0_x, req0_y,
        input  req1_valid, req1_x, req1_y,
        output req0_ready, req1_ready,
        output writeX, writeY, wrEnable
    );
endinterface

// File: rtl/pixel_write_arbiter.sv
// Round-robin arbiter for the single frame-buffer write port: range-checks each
// accepted point, registers it onto the write bus and keeps saturating counts.
module pixel_write_arbiter #(
    parameter logic [8:0] MAX_X  = 9'd479,
    parameter logic [8:0] MAX_Y  = 9'd479,
    parameter int         CNT_W  = 20,
    parameter int         DROP_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    pixel_write_arbiter_if.slave  bus,
    output logic                  last_grant,
    output logic [CNT_W-1:0]      count_written,
    output logic [DROP_W-1:0]     count_dropped
);

    logic       grant0;
    logic       grant1;
    logic       any_grant;
    logic [8:0] grant_x;
    logic [8:0] grant_y;
    logic       in_range;

    logic [8:0] write_x_q;
    logic [8:0] write_y_q;
    logic       wr_enable_q;

    // On contention the requester that was not served last wins.
    always_comb begin
        grant0 = enable && bus.req0_valid && (!bus.req1_valid || last_grant);
        grant1 = enable && bus.req1_valid && (!bus.req0_valid || !last_grant);
    end

    assign any_grant = grant0 || grant1;
    assign grant_x   = grant1 ? bus.req1_x : bus.req0_x;
    assign grant_y   = grant1 ? bus.req1_y : bus.req0_y;
    assign in_range  = (grant_x <= MAX_X) && (grant_y <= MAX_Y);

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.writeX     = write_x_q;
    assign bus.writeY     = write_y_q;
    assign bus.wrEnable   = wr_enable_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_x_q     <= '0;
            write_y_q     <= '0;
            wr_enable_q   <= 1'b0;
            last_grant    <= 1'b1;
            count_written <= '0;
            count_dropped <= '0;
        end else if (any_grant) begin
            last_grant <= grant1;
            write_x_q  <= grant_x;
            write_y_q  <= grant_y;
            // Out-of-range points are still accepted so a requester never stalls.
            if (in_range) begin
                wr_enable_q <= 1'b1;
                if (count_written != '1)
                    count_written <= count_written + 1'b1;
            end else begin
                wr_enable_q <= 1'b0;
                if (count_dropped != '1)
                    count_dropped <= count_dropped + 1'b1;
            end
        end else begin
            wr_enable_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Directed bench for pixel_write_arbiter; a second, narrow-counter instance
// exercises counter saturation in a few cycles.
module tb_pixel_write_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable_a = 1'b0;
    logic        enable_b = 1'b0;
    logic        last_grant_a;
    logic        last_grant_b;
    logic [19:0] count_written_a;
    logic [15:0] count_dropped_a;
    logic [1:0]  count_written_b;
    logic [1:0]  count_dropped_b;

    int pass_cnt = 0;
    int check_cnt = 0;

    pixel_write_arbiter_if bus_a ();
    pixel_write_arbiter_if bus_b ();

    pixel_write_arbiter u_dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable_a),
        .bus           (bus_a),
        .last_grant    (last_grant_a),
        .count_written (count_written_a),
        .count_dropped (count_dropped_a)
    );

    pixel_write_arbiter #(.CNT_W(2), .DROP_W(2)) u_sat (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable_b),
        .bus           (bus_b),
        .last_grant    (last_grant_b),
        .count_written (count_written_b),
        .count_dropped (count_dropped_b)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus_a.req0_valid = 1'b0; bus_a.req0_x = '0; bus_a.req0_y = '0;
        bus_a.req1_valid = 1'b0; bus_a.req1_x = '0; bus_a.req1_y = '0;
        bus_b.req0_valid = 1'b0; bus_b.req0_x = '0; bus_b.req0_y = '0;
        bus_b.req1_valid = 1'b0; bus_b.req1_x = '0; bus_b.req1_y = '0;
        enable_a = 1'b0;
        enable_b = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        tick();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        check_cnt++;
        if ({bus_a.writeX, bus_a.writeY, bus_a.wrEnable, last_grant_a} !== {9'd0, 9'd0, 1'b0, 1'b1}) begin
            $display("FAIL reset_outputs: got x=%0d y=%0d we=%0b lg=%0b, want 0 0 0 1",
                     bus_a.writeX, bus_a.writeY, bus_a.wrEnable, last_grant_a);
        end else pass_cnt++;
        check_cnt++;
        if ({count_written_a, count_dropped_a} !== 36'd0) begin
            $display("FAIL reset_counts: got w=%0d d=%0d, want 0 0", count_written_a, count_dropped_a);
        end else pass_cnt++;
    endtask

    task automatic test_single_write();
        apply_reset();
        enable_a = 1'b1;
        bus_a.req0_valid = 1'b1; bus_a.req0_x = 9'd10; bus_a.req0_y = 9'd20;
        #1;
        check_cnt++;
        if ({bus_a.req0_ready, bus_a.req1_ready} !== 2'b10) begin
            $display("FAIL single_ready: got r0=%0b r1=%0b, want 1 0", bus_a.req0_ready, bus_a.req1_ready);
        end else pass_cnt++;
        tick();
        bus_a.req0_valid = 1'b0;
        #1;
        check_cnt++;
        if ({bus_a.writeX, bus_a.writeY, bus_a.wrEnable, count_written_a} !== {9'd10, 9'd20, 1'b1, 20'd1}) begin
            $display("FAIL single_write: got x=%0d y=%0d we=%0b cw=%0d, want 10 20 1 1",
                     bus_a.writeX, bus_a.writeY, bus_a.wrEnable, count_written_a);
        end else pass_cnt++;
        tick();
        check_cnt++;
        if ({bus_a.wrEnable, bus_a.writeX, last_grant_a} !== {1'b0, 9'd10, 1'b0}) begin
            $display("FAIL single_idle: got we=%0b x=%0d lg=%0b, want 0 10 0",
                     bus_a.wrEnable, bus_a.writeX, last_grant_a);
        end else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic       g;
        logic [8:0] exp_x;
        apply_reset();
        enable_a = 1'b1;
        bus_a.req0_valid = 1'b1; bus_a.req0_x = 9'd1; bus_a.req0_y = 9'd2;
        bus_a.req1_valid = 1'b1; bus_a.req1_x = 9'd3; bus_a.req1_y = 9'd4;
        for (int i = 0; i < 6; i++) begin
            g = (i % 2) == 1;
            exp_x = g ? 9'd3 : 9'd1;
            #1;
            check_cnt++;
            if ({bus_a.req0_ready, bus_a.req1_ready} !== {!g, g}) begin
                $display("FAIL b2b_ready[%0d]: got r0=%0b r1=%0b, want %0b %0b",
                         i, bus_a.req0_ready, bus_a.req1_ready, !g, g);
            end else pass_cnt++;
            tick();
            check_cnt++;
            if ({last_grant_a, bus_a.wrEnable, bus_a.writeX} !== {g, 1'b1, exp_x}) begin
                $display("FAIL b2b_out[%0d]: got lg=%0b we=%0b x=%0d, want %0b 1 %0d",
                         i, last_grant_a, bus_a.wrEnable, bus_a.writeX, g, exp_x);
            end else pass_cnt++;
        end
        bus_a.req0_valid = 1'b0;
        bus_a.req1_valid = 1'b0;
        check_cnt++;
        if (count_written_a !== 20'd6) begin
            $display("FAIL b2b_count: got %0d, want 6", count_written_a);
        end else pass_cnt++;
    endtask

    task automatic test_range();
        apply_reset();
        enable_a = 1'b1;
        bus_a.req1_valid = 1'b1; bus_a.req1_x = 9'd480; bus_a.req1_y = 9'd5;
        #1;
        check_cnt++;
        if (bus_a.req1_ready !== 1'b1) begin
            $display("FAIL range_drop_ready: got %0b, want 1", bus_a.req1_ready);
        end else pass_cnt++;
        tick();
        bus_a.req1_x = 9'd479; bus_a.req1_y = 9'd479;
        #1;
        check_cnt++;
        if ({bus_a.wrEnable, bus_a.writeX, count_dropped_a, count_written_a} !== {1'b0, 9'd480, 16'd1, 20'd0}) begin
            $display("FAIL range_drop: got we=%0b x=%0d cd=%0d cw=%0d, want 0 480 1 0",
                     bus_a.wrEnable, bus_a.writeX, count_dropped_a, count_written_a);
        end else pass_cnt++;
        tick();
        bus_a.req1_valid = 1'b0;
        bus_a.req0_valid = 1'b1; bus_a.req0_x = 9'd5; bus_a.req0_y = 9'd480;
        #1;
        check_cnt++;
        if ({bus_a.wrEnable, bus_a.writeX, bus_a.writeY, count_written_a, count_dropped_a} !== {1'b1, 9'd479, 9'd479, 20'd1, 16'd1}) begin
            $display("FAIL range_edge: got we=%0b x=%0d y=%0d cw=%0d cd=%0d, want 1 479 479 1 1",
                     bus_a.wrEnable, bus_a.writeX, bus_a.writeY, count_written_a, count_dropped_a);
        end else pass_cnt++;
        tick();
        bus_a.req0_valid = 1'b0;
        check_cnt++;
        if ({bus_a.wrEnable, count_dropped_a} !== {1'b0, 16'd2}) begin
            $display("FAIL range_y_drop: got we=%0b cd=%0d, want 0 2", bus_a.wrEnable, count_dropped_a);
        end else pass_cnt++;
    endtask

    task automatic test_enable();
        apply_reset();
        enable_a = 1'b1;
        bus_a.req0_valid = 1'b1; bus_a.req0_x = 9'd30; bus_a.req0_y = 9'd40;
        tick();
        enable_a = 1'b0;
        bus_a.req1_valid = 1'b1; bus_a.req1_x = 9'd50; bus_a.req1_y = 9'd60;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_cnt++;
            if ({bus_a.req0_ready, bus_a.req1_ready} !== 2'b00) begin
                $display("FAIL enable_ready[%0d]: got r0=%0b r1=%0b, want 0 0",
                         i, bus_a.req0_ready, bus_a.req1_ready);
            end else pass_cnt++;
            tick();
            check_cnt++;
            if ({bus_a.wrEnable, last_grant_a, count_written_a, bus_a.writeX} !== {1'b0, 1'b0, 20'd1, 9'd30}) begin
                $display("FAIL enable_hold[%0d]: got we=%0b lg=%0b cw=%0d x=%0d, want 0 0 1 30",
                         i, bus_a.wrEnable, last_grant_a, count_written_a, bus_a.writeX);
            end else pass_cnt++;
        end
        enable_a = 1'b1;
        #1;
        check_cnt++;
        if ({bus_a.req0_ready, bus_a.req1_ready} !== 2'b01) begin
            $display("FAIL enable_resume: got r0=%0b r1=%0b, want 0 1", bus_a.req0_ready, bus_a.req1_ready);
        end else pass_cnt++;
        tick();
        bus_a.req0_valid = 1'b0;
        bus_a.req1_valid = 1'b0;
        check_cnt++;
        if ({last_grant_a, bus_a.writeX, bus_a.wrEnable} !== {1'b1, 9'd50, 1'b1}) begin
            $display("FAIL enable_resume_out: got lg=%0b x=%0d we=%0b, want 1 50 1",
                     last_grant_a, bus_a.writeX, bus_a.wrEnable);
        end else pass_cnt++;
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt;
        apply_reset();
        enable_b = 1'b1;
        bus_b.req0_valid = 1'b1; bus_b.req0_x = 9'd7; bus_b.req0_y = 9'd7;
        for (int i = 1; i <= 5; i++) begin
            exp_cnt = (i >= 3) ? 2'd3 : 2'(i);
            tick();
            check_cnt++;
            if ({count_written_b, bus_b.wrEnable} !== {exp_cnt, 1'b1}) begin
                $display("FAIL sat_written[%0d]: got cw=%0d we=%0b, want %0d 1",
                         i, count_written_b, bus_b.wrEnable, exp_cnt);
            end else pass_cnt++;
        end
        bus_b.req0_x = 9'd500;
        for (int i = 1; i <= 4; i++) begin
            exp_cnt = (i >= 3) ? 2'd3 : 2'(i);
            tick();
            check_cnt++;
            if ({count_dropped_b, count_written_b} !== {exp_cnt, 2'd3}) begin
                $display("FAIL sat_dropped[%0d]: got cd=%0d cw=%0d, want %0d 3",
                         i, count_dropped_b, count_written_b, exp_cnt);
            end else pass_cnt++;
        end
        bus_b.req0_valid = 1'b0;
    endtask

    task automatic test_mid_reset();
        apply_reset();
        enable_a = 1'b1;
        bus_a.req0_valid = 1'b1; bus_a.req0_x = 9'd70; bus_a.req0_y = 9'd80;
        bus_a.req1_valid = 1'b1; bus_a.req1_x = 9'd90; bus_a.req1_y = 9'd100;
        tick();
        check_cnt++;
        if ({bus_a.wrEnable, last_grant_a, bus_a.writeX} !== {1'b1, 1'b0, 9'd70}) begin
            $display("FAIL midrst_pre: got we=%0b lg=%0b x=%0d, want 1 0 70",
                     bus_a.wrEnable, last_grant_a, bus_a.writeX);
        end else pass_cnt++;
        reset = 1'b1;
        #1;
        check_cnt++;
        if ({bus_a.wrEnable, bus_a.writeX, bus_a.writeY, last_grant_a, count_written_a} !== {1'b0, 9'd0, 9'd0, 1'b1, 20'd0}) begin
            $display("FAIL midrst_async: got we=%0b x=%0d y=%0d lg=%0b cw=%0d, want 0 0 0 1 0",
                     bus_a.wrEnable, bus_a.writeX, bus_a.writeY, last_grant_a, count_written_a);
        end else pass_cnt++;
        tick();
        check_cnt++;
        if ({bus_a.wrEnable, count_written_a, last_grant_a} !== {1'b0, 20'd0, 1'b1}) begin
            $display("FAIL midrst_hold: got we=%0b cw=%0d lg=%0b, want 0 0 1",
                     bus_a.wrEnable, count_written_a, last_grant_a);
        end else pass_cnt++;
        reset = 1'b0;
        #1;
        check_cnt++;
        if ({bus_a.req0_ready, bus_a.req1_ready} !== 2'b10) begin
            $display("FAIL midrst_first_grant: got r0=%0b r1=%0b, want 1 0",
                     bus_a.req0_ready, bus_a.req1_ready);
        end else pass_cnt++;
        tick();
        bus_a.req0_valid = 1'b0;
        bus_a.req1_valid = 1'b0;
        check_cnt++;
        if ({bus_a.writeX, bus_a.wrEnable, count_written_a} !== {9'd70, 1'b1, 20'd1}) begin
            $display("FAIL midrst_after: got x=%0d we=%0b cw=%0d, want 70 1 1",
                     bus_a.writeX, bus_a.wrEnable, count_written_a);
        end else pass_cnt++;
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_write();
        test_back_to_back();
        test_range();
        test_enable();
        test_saturation();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
